// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types and constants for the PS/2 host transmit/receive path.
// Rev    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        SHIFT     = 3'd2,
        ACK       = 3'd3,
        WAIT_IDLE = 3'd4
    } tx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_MAX_RETRY  = 2;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_edge_filt.sv
`default_nettype none
// ============================================================================
// Module : ps2_edge_filt
// Brief  : Two-flop synchronizer plus saturating glitch filter with a
//          one-cycle pulse on each filtered high-to-low transition.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_edge_filt #(
    parameter int FILTER_SIZE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam logic [FILTER_SIZE-1:0] C_CNT_MAX = '1;
    localparam logic [FILTER_SIZE-1:0] C_CNT_ONE = FILTER_SIZE'(1);

    logic [1:0]             r_sync;
    logic [FILTER_SIZE-1:0] r_cnt;
    logic                   r_level;
    logic                   r_fall;
    logic                   w_level_next;

    // Level only changes at the saturation ends, giving hysteresis.
    always_comb begin
        w_level_next = r_level;
        if (r_cnt == C_CNT_MAX) begin
            w_level_next = 1'b1;
        end else if (r_cnt == '0) begin
            w_level_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], pin};
            if (r_sync[1] && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end else if (!r_sync[1] && (r_cnt != '0)) begin
                r_cnt <= r_cnt - C_CNT_ONE;
            end
            r_level <= w_level_next;
            r_fall  <= r_level & ~w_level_next;
        end
    end

    assign level = r_level;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx
// Brief  : PS/2 host-to-device command transmitter (inhibit, shift, ACK check).
//          Define PS2_TX_RETRY_EN to retry on NACK/timeout up to PS2_MAX_RETRY.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_SIZE    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int C_INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [C_INH_W-1:0] C_INH_LAST  = C_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [C_INH_W-1:0] C_INH_START = C_INH_W'((INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [C_INH_W-1:0] C_INH_ONE   = C_INH_W'(1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST  = C_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_MAX   = C_TMO_W'(TIMEOUT_CYCLES);
    localparam logic [C_TMO_W-1:0] C_TMO_ONE   = C_TMO_W'(1);
    localparam logic [3:0]         C_STOP_IDX  = 4'(PS2_FRAME_BITS - 2);

    tx_state_t          r_state;
    logic [7:0]         r_data;
    logic               r_parity;
    logic [8:0]         r_shift;
    logic [3:0]         r_bit_idx;
    logic [C_INH_W-1:0] r_inh_cnt;
    logic [C_TMO_W-1:0] r_tmo_cnt;
    logic               r_ack_ok;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_ack_out;
    logic               r_err;
    logic [1:0]         r_data_sync;

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data_s;
    logic w_tmo_active;
    logic w_fall_rearm;
    logic w_idle_done;
    logic w_timeout;
    logic w_can_retry;

    ps2_edge_filt #(
        .FILTER_SIZE (FILTER_SIZE)
    ) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (w_clk_level),
        .fall  (w_clk_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_sync <= 2'b11;
        end else begin
            r_data_sync <= {r_data_sync[0], ps2_data_in};
        end
    end

    assign w_data_s     = r_data_sync[1];
    assign w_tmo_active = (r_state == SHIFT) || (r_state == ACK) || (r_state == WAIT_IDLE);
    // Falls re-arm the watchdog only while the device is still clocking the frame.
    assign w_fall_rearm = w_clk_fall && ((r_state == SHIFT) || (r_state == ACK));
    assign w_idle_done  = (r_state == WAIT_IDLE) && w_clk_level && w_data_s;
    assign w_timeout    = w_tmo_active && (r_tmo_cnt == C_TMO_LAST) && !w_fall_rearm && !w_idle_done;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] r_retry_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE)) begin
            r_retry_cnt <= '0;
        end else if (w_can_retry && (w_timeout || (w_idle_done && !r_ack_ok))) begin
            r_retry_cnt <= r_retry_cnt + 2'd1;
        end
    end

    assign w_can_retry = (r_retry_cnt < 2'(PS2_MAX_RETRY));
`else
    assign w_can_retry = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_ack_ok  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_out <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_out <= 1'b0;
            r_err     <= 1'b0;

            if (w_fall_rearm) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_active && (r_tmo_cnt != C_TMO_MAX)) begin
                r_tmo_cnt <= r_tmo_cnt + C_TMO_ONE;
            end

            case (r_state)
                IDLE: begin
                    if (tx_valid && r_ready) begin
                        r_data    <= tx_data;
                        r_parity  <= odd_parity(tx_data);
                        r_bit_idx <= '0;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    // Start bit goes low one cycle before the clock is released.
                    if (r_inh_cnt == C_INH_START) begin
                        r_data_oe <= 1'b1;
                    end
                    if (r_inh_cnt == C_INH_LAST) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_shift   <= {r_parity, r_data};
                        r_tmo_cnt <= '0;
                        r_state   <= SHIFT;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + C_INH_ONE;
                    end
                end
                SHIFT: begin
                    if (w_clk_fall) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == C_STOP_IDX) begin
                            r_data_oe <= 1'b0;
                            r_state   <= ACK;
                        end else begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[8:1]};
                        end
                    end
                end
                ACK: begin
                    if (w_clk_fall) begin
                        r_ack_ok <= ~w_data_s;
                        r_state  <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (w_idle_done) begin
                        if (!r_ack_ok && w_can_retry) begin
                            r_bit_idx <= '0;
                            r_inh_cnt <= '0;
                            r_clk_oe  <= 1'b1;
                            r_data_oe <= 1'b0;
                            r_state   <= INHIBIT;
                        end else begin
                            r_done    <= 1'b1;
                            r_ack_out <= r_ack_ok;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_timeout) begin
                r_data_oe <= 1'b0;
                r_bit_idx <= '0;
                r_inh_cnt <= '0;
                if (w_can_retry) begin
                    r_clk_oe <= 1'b1;
                    r_state  <= INHIBIT;
                end else begin
                    r_clk_oe <= 1'b0;
                    r_err    <= 1'b1;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            end
        end
    end

    assign tx_ready    = r_ready;
    assign busy        = r_busy;
    assign tx_done     = r_done;
    assign tx_ack_ok   = r_ack_out;
    assign tx_err      = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire
